// File: rtl/paddle_ctrl.sv
// paddle_ctrl: N-player paddle controller for pong.
// Raw up/down buttons are synchronised and debounced. On each frame tick,
// every paddle moves by its current speed, clamped to [POS_MIN, POS_MAX].
// Holding one direction speeds the paddle up one step every ACC_TICKS moves.
module paddle_ctrl #(
    parameter int N_PLY     = 2,
    parameter int POS_W     = 10,
    parameter int POS_MIN   = 8,
    parameter int POS_MAX   = 400,
    parameter int POS_INIT  = 200,
    parameter int DEB_CYC   = 4,
    parameter int SPEED_MIN = 1,
    parameter int SPEED_MAX = 8,
    parameter int ACC_TICKS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick,
    input  logic [N_PLY-1:0]       btn_up,
    input  logic [N_PLY-1:0]       btn_dn,
    output logic [N_PLY*POS_W-1:0] pos,
    output logic [N_PLY-1:0]       moving
);

    localparam int DCW = $clog2(DEB_CYC + 1);
    localparam int ACW = $clog2(ACC_TICKS + 1);

    localparam logic [POS_W-1:0] P_MIN   = POS_W'(POS_MIN);
    localparam logic [POS_W-1:0] P_MAX   = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] P_INIT  = POS_W'(POS_INIT);
    localparam logic [POS_W-1:0] SPD_MIN = POS_W'(SPEED_MIN);
    localparam logic [POS_W-1:0] SPD_MAX = POS_W'(SPEED_MAX);
    localparam logic [DCW-1:0]   DEB_LAST = DCW'(DEB_CYC - 1);
    localparam logic [ACW-1:0]   ACC_LAST = ACW'(ACC_TICKS - 1);

    for (genvar i = 0; i < N_PLY; i++) begin : g_ply
        // Bit 0 is the up button, bit 1 the down button.
        logic [1:0]       raw;
        logic [1:0]       s1;
        logic [1:0]       s2;
        logic [1:0]       deb;
        logic [DCW-1:0]   cnt [2];

        logic [POS_W-1:0] pos_q;
        logic [POS_W-1:0] speed_q;
        logic [ACW-1:0]   acc_q;
        logic             dir_q;      // direction of last move, 1 = down
        logic             mov_q;

        logic             go_up;
        logic             go_dn;
        logic             same;
        logic [POS_W-1:0] cur_speed;
        logic [ACW-1:0]   cur_acc;
        logic [POS_W:0]   diff;
        logic [POS_W:0]   sum;
        logic [POS_W-1:0] new_pos;

        assign raw = {btn_dn[i], btn_up[i]};

        // Two-flop synchroniser followed by a stability-counting debouncer.
        always_ff @(posedge clk) begin
            if (reset) begin
                s1     <= '0;
                s2     <= '0;
                deb    <= '0;
                cnt[0] <= '0;
                cnt[1] <= '0;
            end else begin
                s1 <= raw;
                s2 <= s1;
                for (int b = 0; b < 2; b++) begin
                    // Any return to the accepted level restarts the count.
                    if (s2[b] == deb[b]) begin
                        cnt[b] <= '0;
                    end else if (cnt[b] == DEB_LAST) begin
                        deb[b] <= s2[b];
                        cnt[b] <= '0;
                    end else begin
                        cnt[b] <= cnt[b] + 1'b1;
                    end
                end
            end
        end

        // Candidate position for this tick, using the effective speed.
        always_comb begin
            go_up     = deb[0] & ~deb[1];
            go_dn     = deb[1] & ~deb[0];
            // A direction change restarts acceleration before moving.
            same      = (go_dn == dir_q);
            cur_speed = same ? speed_q : SPD_MIN;
            cur_acc   = same ? acc_q : '0;
            diff      = {1'b0, pos_q} - {1'b0, cur_speed};
            sum       = {1'b0, pos_q} + {1'b0, cur_speed};
            new_pos   = pos_q;
            if (go_up) begin
                // Borrow out of the top bit means we went below zero.
                if (diff[POS_W] || (diff < {1'b0, P_MIN})) begin
                    new_pos = P_MIN;
                end else begin
                    new_pos = diff[POS_W-1:0];
                end
            end else if (go_dn) begin
                if (sum > {1'b0, P_MAX}) begin
                    new_pos = P_MAX;
                end else begin
                    new_pos = sum[POS_W-1:0];
                end
            end
        end

        // Per-tick position, speed and acceleration update.
        always_ff @(posedge clk) begin
            if (reset) begin
                pos_q   <= P_INIT;
                speed_q <= SPD_MIN;
                acc_q   <= '0;
                dir_q   <= 1'b0;
                mov_q   <= 1'b0;
            end else begin
                mov_q <= 1'b0;
                if (tick) begin
                    if (go_up || go_dn) begin
                        pos_q <= new_pos;
                        mov_q <= (new_pos != pos_q);
                        dir_q <= go_dn;
                        if (cur_acc == ACC_LAST) begin
                            acc_q   <= '0;
                            speed_q <= (cur_speed >= SPD_MAX) ? SPD_MAX : cur_speed + 1'b1;
                        end else begin
                            acc_q   <= cur_acc + 1'b1;
                            speed_q <= cur_speed;
                        end
                    end else begin
                        speed_q <= SPD_MIN;
                        acc_q   <= '0;
                    end
                end
            end
        end

        assign pos[i*POS_W +: POS_W] = pos_q;
        assign moving[i]             = mov_q;
    end

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl: directed scenarios for paddle_ctrl. Each tick pushes the
// expected {moving, pos1, pos0} into exp_q; a monitor pops and compares on
// the cycle after every sampled tick and checks moving stays low otherwise.
module tb_paddle_ctrl;

    localparam int POS_W = 10;
    localparam int EW    = 2 + 2 * POS_W;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 tick;
    logic [1:0]           btn_up;
    logic [1:0]           btn_dn;
    logic [2*POS_W-1:0]   pos;
    logic [1:0]           moving;

    logic [EW-1:0] exp_q[$];
    int            checks   = 0;
    int            failures = 0;
    int            exp_p[2];
    logic          tick_seen = 1'b0;
    logic          mon_en    = 1'b0;

    paddle_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .btn_up (btn_up),
        .btn_dn (btn_dn),
        .pos    (pos),
        .moving (moving)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Remember whether the DUT sampled a tick on this edge.
    always @(posedge clk) tick_seen <= tick;

    // Monitor: compare after each sampled tick, otherwise moving must be low.
    initial begin
        logic [EW-1:0] exp_v;
        logic [EW-1:0] act_v;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                act_v = {moving, pos};
                if (tick_seen) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL tick_unexpected act=%h exp=<none>", act_v);
                    end else begin
                        exp_v = exp_q.pop_front();
                        if (act_v !== exp_v) begin
                            failures++;
                            $display("FAIL tick_resp act mv=%b p1=%0d p0=%0d exp mv=%b p1=%0d p0=%0d",
                                     act_v[EW-1 -: 2], act_v[2*POS_W-1 -: POS_W], act_v[POS_W-1:0],
                                     exp_v[EW-1 -: 2], exp_v[2*POS_W-1 -: POS_W], exp_v[POS_W-1:0]);
                        end
                    end
                end else begin
                    checks++;
                    if (moving !== 2'b00) begin
                        failures++;
                        $display("FAIL idle_moving act=%b exp=00", moving);
                    end
                end
            end
        end
    end

    // One-cycle tick with its expected response queued first.
    task automatic do_tick(input int p0, input int p1, input logic [1:0] mv);
        @(negedge clk);
        exp_q.push_back({mv, POS_W'(p1), POS_W'(p0)});
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference for a held button: k-th move of a hold uses speed min(1+k/4, 8).
    task automatic hold_ticks(input int plr, input bit down, input int k0, input int n);
        int spd;
        int np;
        logic [1:0] mv;
        for (int k = k0; k < k0 + n; k++) begin
            spd = 1 + k / 4;
            if (spd > 8) spd = 8;
            np = down ? exp_p[plr] + spd : exp_p[plr] - spd;
            if (np < 8) np = 8;
            if (np > 400) np = 400;
            mv = 2'b00;
            mv[plr] = (np != exp_p[plr]);
            exp_p[plr] = np;
            do_tick(exp_p[0], exp_p[1], mv);
        end
    endtask

    // Directed stimulus.
    initial begin
        int up_seq[12];
        up_seq = '{199, 198, 197, 196, 194, 192, 190, 188, 185, 182, 179, 176};
        reset  = 1'b1;
        tick   = 1'b0;
        btn_up = 2'b00;
        btn_dn = 2'b00;
        exp_p  = '{200, 200};

        // Reset for two cycles, then a tick while still in reset.
        wait_cyc(2);
        mon_en = 1'b1;
        do_tick(200, 200, 2'b00);
        reset = 1'b0;
        wait_cyc(2);

        // Hold up on player 0 for 12 ticks.
        btn_up[0] = 1'b1;
        wait_cyc(8);
        for (int t = 0; t < 12; t++) do_tick(up_seq[t], 200, 2'b01);
        exp_p[0] = 176;
        btn_up[0] = 1'b0;
        wait_cyc(8);

        // Hold down on player 1 until clamped, then keep holding.
        btn_dn[1] = 1'b1;
        wait_cyc(8);
        hold_ticks(1, 1'b1, 0, 41);
        // Reverse: first move uses the minimum speed again.
        btn_dn[1] = 1'b0;
        btn_up[1] = 1'b1;
        wait_cyc(8);
        hold_ticks(1, 1'b0, 0, 1);

        // Both buttons on player 0: no movement.
        btn_up[1] = 1'b0;
        btn_up[0] = 1'b1;
        btn_dn[0] = 1'b1;
        wait_cyc(8);
        do_tick(exp_p[0], exp_p[1], 2'b00);
        do_tick(exp_p[0], exp_p[1], 2'b00);
        btn_dn[0] = 1'b0;
        wait_cyc(8);
        hold_ticks(0, 1'b0, 0, 1);

        // Short glitch is rejected.
        btn_up[0] = 1'b0;
        wait_cyc(8);
        btn_up[0] = 1'b1;
        wait_cyc(3);
        btn_up[0] = 1'b0;
        wait_cyc(8);
        do_tick(exp_p[0], exp_p[1], 2'b00);
        do_tick(exp_p[0], exp_p[1], 2'b00);

        // Press held exactly 2+DEB_CYC cycles before the tick edge is accepted.
        btn_up[0] = 1'b1;
        wait_cyc(5);
        hold_ticks(0, 1'b0, 0, 1);
        // Keep holding until speed 5.
        hold_ticks(0, 1'b0, 1, 16);

        // Reset mid-hold, with a tick during reset.
        @(negedge clk);
        reset = 1'b1;
        exp_p = '{200, 200};
        do_tick(200, 200, 2'b00);
        reset = 1'b0;
        // Debounce has not re-qualified yet.
        do_tick(200, 200, 2'b00);
        wait_cyc(8);
        hold_ticks(0, 1'b0, 0, 1);

        wait_cyc(4);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain act=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
